debug_dma_host_ctrl: RTL and testbench

Host-side master for the on-chip debug DMA engine. It accepts one transfer request at a time from the host link and programs the DMA command interface: address register, then control register. It waits for the IU to report completion for the target thread, then drains the DMA write buffer (the data the IU wrote back from injected loads) to the host as a word stream with parity checking. It sits between the host/Ethernet debug front end and the DMA engine's command interface and write buffer.

---
 rtl/debug_dma_host_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_debug_dma_host_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dma_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_dma_host_ctrl
// Purpose  : Host-side master that programs the debug DMA command registers,
//            waits for IU completion and drains the write buffer to the host.
// Revision : 1.0 - initial release
// ============================================================================
module debug_dma_host_ctrl #(
   parameter int NTHREADIDMSB = 5,
   parameter int DMABUFMSB    = 9,
   parameter int TIMEOUT      = 65535
) (
   input  logic                  gclk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [NTHREADIDMSB:0] req_tid_i,
   input  logic [29:0]           req_vaddr_i,
   input  logic [DMABUFMSB:0]    req_buf_addr_i,
   input  logic [DMABUFMSB:0]    req_count_i,
   input  logic                  req_rd_i,
   output logic [NTHREADIDMSB:0] cmd_tid_o,
   output logic [29:0]           cmd_addr_o,
   output logic                  cmd_addr_parity_o,
   output logic                  cmd_addr_we_o,
   output logic [DMABUFMSB:0]    cmd_buf_addr_o,
   output logic [DMABUFMSB:0]    cmd_count_o,
   output logic                  cmd_op_o,
   output logic                  cmd_ctrl_parity_o,
   output logic                  cmd_ctrl_we_o,
   input  logic                  dma_done_i,
   input  logic [NTHREADIDMSB:0] dma_done_tid_i,
   output logic [DMABUFMSB:0]    wbuf_addr_o,
   input  logic [31:0]           wbuf_data_i,
   input  logic                  wbuf_parity_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_data_o,
   output logic                  rsp_last_o,
   output logic                  rsp_perr_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);

   localparam int TMW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMW-1:0] TIMEOUT_C = TMW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WADDR = 3'd1,
      S_WCTRL = 3'd2,
      S_WAIT  = 3'd3,
      S_RD    = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [DMABUFMSB:0]    k_q, k_d;
   logic [TMW-1:0]        timer_q, timer_d;
   logic [NTHREADIDMSB:0] cmd_tid_q, cmd_tid_d;
   logic [29:0]           cmd_addr_q, cmd_addr_d;
   logic [DMABUFMSB:0]    cmd_buf_addr_q, cmd_buf_addr_d;
   logic [DMABUFMSB:0]    cmd_count_q, cmd_count_d;
   logic                  rd_q, rd_d;
   logic [DMABUFMSB:0]    wbuf_addr_q, wbuf_addr_d;
   logic                  fresh_q, fresh_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic                  rsp_last_q, rsp_last_d;
   logic                  rsp_perr_q, rsp_perr_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  wbuf_perr;
   logic                  in_resp;

   assign wbuf_perr = wbuf_parity_i != (^wbuf_data_i);
   assign in_resp   = (state_q == S_RESP);

   always_ff @(posedge gclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         k_q            <= '0;
         timer_q        <= '0;
         cmd_tid_q      <= '0;
         cmd_addr_q     <= '0;
         cmd_buf_addr_q <= '0;
         cmd_count_q    <= '0;
         rd_q           <= 1'b0;
         wbuf_addr_q    <= '0;
         fresh_q        <= 1'b0;
         rsp_data_q     <= '0;
         rsp_last_q     <= 1'b0;
         rsp_perr_q     <= 1'b0;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         k_q            <= k_d;
         timer_q        <= timer_d;
         cmd_tid_q      <= cmd_tid_d;
         cmd_addr_q     <= cmd_addr_d;
         cmd_buf_addr_q <= cmd_buf_addr_d;
         cmd_count_q    <= cmd_count_d;
         rd_q           <= rd_d;
         wbuf_addr_q    <= wbuf_addr_d;
         fresh_q        <= fresh_d;
         rsp_data_q     <= rsp_data_d;
         rsp_last_q     <= rsp_last_d;
         rsp_perr_q     <= rsp_perr_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      timer_d        = timer_q;
      cmd_tid_d      = cmd_tid_q;
      cmd_addr_d     = cmd_addr_q;
      cmd_buf_addr_d = cmd_buf_addr_q;
      cmd_count_d    = cmd_count_q;
      rd_d           = rd_q;
      wbuf_addr_d    = wbuf_addr_q;
      fresh_d        = 1'b0;
      rsp_data_d     = rsp_data_q;
      rsp_last_d     = rsp_last_q;
      rsp_perr_d     = rsp_perr_q;
      rsp_err_d      = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               cmd_tid_d      = req_tid_i;
               cmd_addr_d     = req_vaddr_i;
               cmd_buf_addr_d = req_buf_addr_i;
               cmd_count_d    = req_count_i;
               rd_d           = req_rd_i;
               k_d            = '0;
               timer_d        = '0;
               state_d        = S_WADDR;
            end
         end
         S_WADDR: state_d = S_WCTRL;
         S_WCTRL: state_d = S_WAIT;
         S_WAIT: begin
            // A matching completion wins over a timeout landing on the same cycle.
            if (dma_done_i && (dma_done_tid_i == cmd_tid_q)) begin
               if (rd_q) begin
                  k_d         = '0;
                  wbuf_addr_d = cmd_buf_addr_q;
                  state_d     = S_RD;
               end else begin
                  rsp_data_d = '0;
                  rsp_last_d = 1'b1;
                  rsp_perr_d = 1'b0;
                  rsp_err_d  = 1'b0;
                  state_d    = S_RESP;
               end
            end else if (timer_q == TIMEOUT_C) begin
               rsp_data_d = 32'hFFFF_FFFF;
               rsp_last_d = 1'b1;
               rsp_perr_d = 1'b0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               timer_d = timer_q + TMW'(1);
            end
         end
         S_RD: begin
            rsp_last_d = (k_q == cmd_count_q);
            rsp_err_d  = 1'b0;
            fresh_d    = 1'b1;
            state_d    = S_RESP;
         end
         S_RESP: begin
            // Buffer data arrives on the first RESP cycle; capture it so the beat stays stable.
            if (fresh_q) begin
               rsp_data_d = wbuf_data_i;
               rsp_perr_d = wbuf_perr;
            end
            if (rsp_ready_i) begin
               if (rsp_last_q) begin
                  state_d = S_IDLE;
               end else begin
                  k_d         = k_q + DMABUFMSB'(1) + 1'b0;
                  wbuf_addr_d = cmd_buf_addr_q + k_q + (DMABUFMSB+1)'(1);
                  state_d     = S_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready_o       = (state_q == S_IDLE);
   assign busy_o            = (state_q != S_IDLE);
   assign cmd_tid_o         = cmd_tid_q;
   assign cmd_addr_o        = cmd_addr_q;
   assign cmd_addr_parity_o = ^cmd_addr_q;
   assign cmd_addr_we_o     = (state_q == S_WADDR);
   assign cmd_buf_addr_o    = cmd_buf_addr_q;
   assign cmd_count_o       = cmd_count_q;
   assign cmd_op_o          = (state_q == S_WCTRL);
   assign cmd_ctrl_parity_o = ^{cmd_buf_addr_q, cmd_count_q, cmd_op_o};
   assign cmd_ctrl_we_o     = (state_q == S_WCTRL);
   assign wbuf_addr_o       = wbuf_addr_q;
   assign rsp_valid_o       = in_resp;
   assign rsp_data_o        = in_resp ? (fresh_q ? wbuf_data_i : rsp_data_q) : '0;
   assign rsp_last_o        = in_resp & rsp_last_q;
   assign rsp_perr_o        = in_resp & (fresh_q ? wbuf_perr : rsp_perr_q);
   assign rsp_err_o         = in_resp & rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_dma_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_dma_host_ctrl
// Purpose  : Directed self-checking bench for debug_dma_host_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_dma_host_ctrl;

   logic        gclk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_tid;
   logic [29:0] req_vaddr;
   logic [9:0]  req_buf_addr;
   logic [9:0]  req_count;
   logic        req_rd;
   logic [5:0]  cmd_tid;
   logic [29:0] cmd_addr;
   logic        cmd_addr_parity;
   logic        cmd_addr_we;
   logic [9:0]  cmd_buf_addr;
   logic [9:0]  cmd_count;
   logic        cmd_op;
   logic        cmd_ctrl_parity;
   logic        cmd_ctrl_we;
   logic        dma_done;
   logic [5:0]  dma_done_tid;
   logic [9:0]  wbuf_addr;
   logic [31:0] wbuf_data;
   logic        wbuf_parity;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        rsp_perr;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem  [1024];
   logic        mpar [1024];

   logic [31:0] bdata [32];
   logic        blast [32];
   logic        bperr [32];
   logic        berr  [32];
   logic [9:0]  baddr [32];
   int          bcyc  [32];
   int          nbeats;
   logic        timed_out;
   logic        hold_unstable;

   always #5 gclk = ~gclk;

   // Write buffer with one-cycle read latency.
   always @(posedge gclk) begin
      wbuf_data   <= mem[wbuf_addr];
      wbuf_parity <= mpar[wbuf_addr];
   end

   debug_dma_host_ctrl #(
      .NTHREADIDMSB(5),
      .DMABUFMSB   (9),
      .TIMEOUT     (16)
   ) dut (
      .gclk_i           (gclk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_tid_i        (req_tid),
      .req_vaddr_i      (req_vaddr),
      .req_buf_addr_i   (req_buf_addr),
      .req_count_i      (req_count),
      .req_rd_i         (req_rd),
      .cmd_tid_o        (cmd_tid),
      .cmd_addr_o       (cmd_addr),
      .cmd_addr_parity_o(cmd_addr_parity),
      .cmd_addr_we_o    (cmd_addr_we),
      .cmd_buf_addr_o   (cmd_buf_addr),
      .cmd_count_o      (cmd_count),
      .cmd_op_o         (cmd_op),
      .cmd_ctrl_parity_o(cmd_ctrl_parity),
      .cmd_ctrl_we_o    (cmd_ctrl_we),
      .dma_done_i       (dma_done),
      .dma_done_tid_i   (dma_done_tid),
      .wbuf_addr_o      (wbuf_addr),
      .wbuf_data_i      (wbuf_data),
      .wbuf_parity_i    (wbuf_parity),
      .rsp_valid_o      (rsp_valid),
      .rsp_ready_i      (rsp_ready),
      .rsp_data_o       (rsp_data),
      .rsp_last_o       (rsp_last),
      .rsp_perr_o       (rsp_perr),
      .rsp_err_o        (rsp_err),
      .busy_o           (busy)
   );

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   // Presents one request in the current cycle; returns in the first WAIT cycle.
   task automatic issue_req(input logic [5:0] tid, input logic [29:0] va,
                            input logic [9:0] ba, input logic [9:0] cnt, input logic rd);
      req_tid = tid; req_vaddr = va; req_buf_addr = ba; req_count = cnt; req_rd = rd;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
   endtask

   // Called in the cycle dma_done is driven; records every beat until the last handshake.
   task automatic collect(input int hold_beat, input int hold_len);
      int  c;
      int  held;
      logic pending;
      logic last_hs;
      nbeats = 0; timed_out = 1'b1; hold_unstable = 1'b0;
      held = 0; pending = 1'b0; last_hs = 1'b0;
      tick();
      dma_done = 1'b0;
      c = 1;
      while (c < 200 && nbeats < 31) begin
         last_hs = 1'b0;
         if (rsp_valid) begin
            if (!pending) begin
               bdata[nbeats] = rsp_data; blast[nbeats] = rsp_last;
               bperr[nbeats] = rsp_perr; berr[nbeats]  = rsp_err;
               baddr[nbeats] = wbuf_addr; bcyc[nbeats] = c;
               pending = 1'b1; held = 0;
            end else if (rsp_data !== bdata[nbeats] || rsp_last !== blast[nbeats] ||
                         rsp_perr !== bperr[nbeats] || rsp_err !== berr[nbeats]) begin
               hold_unstable = 1'b1;
            end
            if (nbeats == hold_beat && held < hold_len) begin
               rsp_ready = 1'b0;
               held++;
            end else begin
               rsp_ready = 1'b1;
               pending   = 1'b0;
               last_hs   = rsp_last;
               nbeats++;
            end
         end else begin
            if (pending) hold_unstable = 1'b1;
            rsp_ready = 1'b1;
         end
         tick();
         c++;
         if (last_hs) begin
            timed_out = 1'b0;
            break;
         end
      end
      rsp_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_handshake: req_ready=%b busy=%b, want 1 0", req_ready, busy);
      end
      checks++;
      if (cmd_tid !== 6'd0 || cmd_addr !== 30'd0 || cmd_buf_addr !== 10'd0 || cmd_count !== 10'd0) begin
         errors++; $display("FAIL reset_cmd_fields: tid=%h addr=%h buf=%h cnt=%h, want 0", cmd_tid, cmd_addr, cmd_buf_addr, cmd_count);
      end
      checks++;
      if (cmd_addr_we !== 1'b0 || cmd_ctrl_we !== 1'b0 || cmd_op !== 1'b0 ||
          cmd_addr_parity !== 1'b0 || cmd_ctrl_parity !== 1'b0) begin
         errors++; $display("FAIL reset_cmd_strobes: awe=%b cwe=%b op=%b ap=%b cp=%b, want 0", cmd_addr_we, cmd_ctrl_we, cmd_op, cmd_addr_parity, cmd_ctrl_parity);
      end
      checks++;
      if (wbuf_addr !== 10'd0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 ||
          rsp_last !== 1'b0 || rsp_perr !== 1'b0 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL reset_rsp: wa=%h v=%b d=%h l=%b pe=%b e=%b, want 0", wbuf_addr, rsp_valid, rsp_data, rsp_last, rsp_perr, rsp_err);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_basic();
      logic       exp_par;
      logic [9:0] ba;
      logic [9:0] cnt;
      ba = 10'd0; cnt = 10'd3;
      req_tid = 6'd3; req_vaddr = 30'h100; req_buf_addr = ba; req_count = cnt; req_rd = 1'b1;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      checks++;
      if (cmd_addr_we !== 1'b1 || cmd_ctrl_we !== 1'b0 || cmd_op !== 1'b0) begin
         errors++; $display("FAIL basic_addr_we: awe=%b cwe=%b op=%b, want 1 0 0", cmd_addr_we, cmd_ctrl_we, cmd_op);
      end
      checks++;
      if (cmd_addr !== 30'h100 || cmd_addr_parity !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++; $display("FAIL basic_addr_reg: addr=%h par=%b busy=%b rdy=%b, want 100 1 1 0", cmd_addr, cmd_addr_parity, busy, req_ready);
      end
      tick();
      exp_par = ^{ba, cnt, 1'b1};
      checks++;
      if (cmd_ctrl_we !== 1'b1 || cmd_addr_we !== 1'b0 || cmd_op !== 1'b1 ||
          cmd_buf_addr !== ba || cmd_count !== cnt || cmd_ctrl_parity !== exp_par || cmd_tid !== 6'd3) begin
         errors++; $display("FAIL basic_ctrl_we: cwe=%b awe=%b op=%b buf=%h cnt=%h par=%b tid=%h, want 1 0 1 %h %h %b 03",
                            cmd_ctrl_we, cmd_addr_we, cmd_op, cmd_buf_addr, cmd_count, cmd_ctrl_parity, cmd_tid, ba, cnt, exp_par);
      end
      tick();
      exp_par = ^{ba, cnt, 1'b0};
      checks++;
      if (cmd_ctrl_we !== 1'b0 || cmd_op !== 1'b0 || cmd_ctrl_parity !== exp_par) begin
         errors++; $display("FAIL basic_wait_entry: cwe=%b op=%b par=%b, want 0 0 %b", cmd_ctrl_we, cmd_op, cmd_ctrl_parity, exp_par);
      end
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_waiting: rsp_valid=%b busy=%b, want 0 1", rsp_valid, busy);
      end
      dma_done = 1'b1; dma_done_tid = 6'd3;
      collect(-1, 0);
      checks++;
      if (nbeats !== 4 || timed_out !== 1'b0) begin
         errors++; $display("FAIL basic_beats: beats=%0d timeout=%b, want 4 0", nbeats, timed_out);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (baddr[i] !== 10'(i) || bdata[i] !== mem[i] || blast[i] !== (i == 3) ||
             bperr[i] !== 1'b0 || berr[i] !== 1'b0) begin
            errors++; $display("FAIL basic_beat%0d: addr=%0d data=%h last=%b perr=%b err=%b, want %0d %h %b 0 0",
                               i, baddr[i], bdata[i], blast[i], bperr[i], berr[i], i, mem[i], (i == 3));
         end
      end
      checks++;
      if (bcyc[0] !== 2 || bcyc[1] !== 4) begin
         errors++; $display("FAIL basic_latency: first=%0d second=%0d, want 2 4", bcyc[0], bcyc[1]);
      end
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || cmd_tid !== 6'd3 || cmd_addr !== 30'h100) begin
         errors++; $display("FAIL basic_idle: busy=%b rdy=%b tid=%h addr=%h, want 0 1 03 100", busy, req_ready, cmd_tid, cmd_addr);
      end
   endtask

   task automatic test_write_ack();
      logic [29:0] va;
      va = 30'h2AB_CDE7;
      req_tid = 6'd7; req_vaddr = va; req_buf_addr = 10'd5; req_count = 10'd0; req_rd = 1'b0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      dma_done = 1'b1; dma_done_tid = 6'd7;
      checks++;
      if (cmd_addr_parity !== (^va)) begin
         errors++; $display("FAIL ack_addr_parity: par=%b, want %b", cmd_addr_parity, ^va);
      end
      tick();
      dma_done = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL ack_early_done_ignored: rsp_valid=%b busy=%b, want 0 1", rsp_valid, busy);
      end
      dma_done = 1'b1; dma_done_tid = 6'd7;
      collect(-1, 0);
      checks++;
      if (nbeats !== 1 || timed_out !== 1'b0 || bcyc[0] !== 1) begin
         errors++; $display("FAIL ack_beats: beats=%0d timeout=%b cyc=%0d, want 1 0 1", nbeats, timed_out, bcyc[0]);
      end
      checks++;
      if (bdata[0] !== 32'd0 || blast[0] !== 1'b1 || berr[0] !== 1'b0 || bperr[0] !== 1'b0) begin
         errors++; $display("FAIL ack_beat: data=%h last=%b err=%b perr=%b, want 0 1 0 0", bdata[0], blast[0], berr[0], bperr[0]);
      end
   endtask

   task automatic test_wrap();
      logic [9:0] exp_a;
      issue_req(6'd3, 30'h40, 10'd1022, 10'd3, 1'b1);
      dma_done = 1'b1; dma_done_tid = 6'd3;
      collect(-1, 0);
      checks++;
      if (nbeats !== 4 || timed_out !== 1'b0) begin
         errors++; $display("FAIL wrap_beats: beats=%0d timeout=%b, want 4 0", nbeats, timed_out);
      end
      for (int i = 0; i < 4; i++) begin
         exp_a = 10'((1022 + i) % 1024);
         checks++;
         if (baddr[i] !== exp_a || bdata[i] !== mem[exp_a] || blast[i] !== (i == 3)) begin
            errors++; $display("FAIL wrap_beat%0d: addr=%0d data=%h last=%b, want %0d %h %b",
                               i, baddr[i], bdata[i], blast[i], exp_a, mem[exp_a], (i == 3));
         end
      end
   endtask

   task automatic test_timeout();
      int first;
      first = -1;
      issue_req(6'd3, 30'h80, 10'd0, 10'd0, 1'b1);
      for (int n = 0; n < 40; n++) begin
         if (n == 2) begin dma_done = 1'b1; dma_done_tid = 6'd5; end
         if (n == 3) dma_done = 1'b0;
         if (rsp_valid) begin
            first = n;
            break;
         end
         tick();
      end
      checks++;
      if (first !== 17) begin
         errors++; $display("FAIL timeout_latency: rsp_valid at WAIT+%0d, want WAIT+17", first);
      end
      checks++;
      if (rsp_data !== 32'hFFFF_FFFF || rsp_last !== 1'b1 || rsp_err !== 1'b1 || rsp_perr !== 1'b0) begin
         errors++; $display("FAIL timeout_beat: data=%h last=%b err=%b perr=%b, want ffffffff 1 1 0", rsp_data, rsp_last, rsp_err, rsp_perr);
      end
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_idle: busy=%b rdy=%b valid=%b, want 0 1 0", busy, req_ready, rsp_valid);
      end
   endtask

   task automatic test_perr_hold();
      mpar[2] = ~mpar[2];
      issue_req(6'd2, 30'h200, 10'd0, 10'd3, 1'b1);
      dma_done = 1'b1; dma_done_tid = 6'd2;
      collect(2, 5);
      checks++;
      if (nbeats !== 4 || timed_out !== 1'b0) begin
         errors++; $display("FAIL perr_beats: beats=%0d timeout=%b, want 4 0", nbeats, timed_out);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bperr[i] !== (i == 2) || bdata[i] !== mem[i]) begin
            errors++; $display("FAIL perr_beat%0d: perr=%b data=%h, want %b %h", i, bperr[i], bdata[i], (i == 2), mem[i]);
         end
      end
      checks++;
      if (hold_unstable !== 1'b0) begin
         errors++; $display("FAIL hold_stable: beat changed while rsp_ready low (flag=%b), want 0", hold_unstable);
      end
      checks++;
      if (bcyc[3] - bcyc[2] !== 7) begin
         errors++; $display("FAIL hold_gap: gap=%0d, want 7", bcyc[3] - bcyc[2]);
      end
      mpar[2] = ~mpar[2];
   endtask

   task automatic test_reset_mid();
      issue_req(6'd4, 30'h155, 10'd8, 10'd2, 1'b1);
      dma_done = 1'b1; dma_done_tid = 6'd4;
      tick();
      dma_done = 1'b0;
      rsp_ready = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL midrst_in_resp: rsp_valid=%b, want 1", rsp_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1 ||
          wbuf_addr !== 10'd0 || cmd_addr !== 30'd0 || cmd_tid !== 6'd0) begin
         errors++; $display("FAIL midrst_async: valid=%b data=%h busy=%b rdy=%b wa=%h addr=%h tid=%h, want 0 0 0 1 0 0 0",
                            rsp_valid, rsp_data, busy, req_ready, wbuf_addr, cmd_addr, cmd_tid);
      end
      tick();
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      tick();
      dma_done = 1'b1; dma_done_tid = 6'd4;
      tick();
      dma_done = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_stale_done: busy=%b valid=%b, want 0 0", busy, rsp_valid);
      end
      issue_req(6'd1, 30'h55, 10'd10, 10'd1, 1'b1);
      dma_done = 1'b1; dma_done_tid = 6'd1;
      collect(-1, 0);
      checks++;
      if (nbeats !== 2 || timed_out !== 1'b0 || baddr[0] !== 10'd10 || baddr[1] !== 10'd11 ||
          bdata[0] !== mem[10] || bdata[1] !== mem[11] || blast[1] !== 1'b1 || blast[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_recover: beats=%0d to=%b a0=%0d a1=%0d d0=%h d1=%h l0=%b l1=%b, want 2 0 10 11 %h %h 0 1",
                            nbeats, timed_out, baddr[0], baddr[1], bdata[0], bdata[1], blast[0], blast[1], mem[10], mem[11]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_tid = '0; req_vaddr = '0; req_buf_addr = '0;
      req_count = '0; req_rd = 1'b0; dma_done = 1'b0; dma_done_tid = '0; rsp_ready = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         mem[i]  = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
         mpar[i] = ^mem[i];
      end
      test_reset();
      test_read_basic();
      tick();
      test_write_ack();
      tick();
      test_wrap();
      tick();
      test_timeout();
      tick();
      test_perr_hold();
      tick();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
